// File: rtl/muldiv_arbiter.sv
// Round-robin arbiter sharing one iterative multiply/divide unit between two issue slots.
// One op in flight; result returns with its tag and source over a valid/ready channel.
module muldiv_arbiter #(
   parameter int TAG_W   = 4,
   parameter int TIMEOUT = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush_i,
   input  logic             req0_valid_i,
   output logic             req0_ready_o,
   input  logic [31:0]      req0_op1_i,
   input  logic [31:0]      req0_op2_i,
   input  logic [7:0]       req0_op_i,
   input  logic [TAG_W-1:0] req0_tag_i,
   input  logic             req1_valid_i,
   output logic             req1_ready_o,
   input  logic [31:0]      req1_op1_i,
   input  logic [31:0]      req1_op2_i,
   input  logic [7:0]       req1_op_i,
   input  logic [TAG_W-1:0] req1_tag_i,
   output logic             mdu_start_o,
   output logic [31:0]      mdu_op1_o,
   output logic [31:0]      mdu_op2_o,
   output logic [7:0]       mdu_op_o,
   input  logic             mdu_done_i,
   input  logic [31:0]      mdu_result_i,
   output logic             resp_valid_o,
   input  logic             resp_ready_i,
   output logic [31:0]      resp_data_o,
   output logic [TAG_W-1:0] resp_tag_o,
   output logic             resp_src_o,
   output logic             busy_o,
   output logic             timeout_o
);
   // Request handshake: a requester's op transfers on a rising edge where valid and ready are both 1;
   // response transfers where resp_valid_o and resp_ready_i are both 1 and flush_i is 0.
   typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

   state_t           state_q, state_d;
   logic             last_grant_q, last_grant_d;
   logic [31:0]      op1_q, op1_d, op2_q, op2_d;
   logic [7:0]       op_q, op_d;
   logic [TAG_W-1:0] tag_q, tag_d;
   logic             src_q, src_d;
   logic             start_q, start_d;
   logic             resp_valid_q, resp_valid_d;
   logic [31:0]      resp_data_q, resp_data_d;
   logic [7:0]       count_q, count_d;
   logic             grant0, grant1, idle_open, exec_done;

   always_comb begin
      grant0       = req0_valid_i & (~req1_valid_i | last_grant_q);
      grant1       = req1_valid_i & (~req0_valid_i | ~last_grant_q);
      idle_open    = (state_q == IDLE) & ~flush_i & ~rst;
      req0_ready_o = idle_open & grant0;
      req1_ready_o = idle_open & grant1;
      // A done in the start cycle cannot belong to this op.
      exec_done    = (state_q == EXEC) & ~start_q & mdu_done_i;
      timeout_o    = (state_q == EXEC) & ~flush_i & ~exec_done & (count_q == 8'(TIMEOUT - 1));

      state_d      = state_q;
      last_grant_d = last_grant_q;
      op1_d        = op1_q;
      op2_d        = op2_q;
      op_d         = op_q;
      tag_d        = tag_q;
      src_d        = src_q;
      start_d      = 1'b0;
      resp_valid_d = resp_valid_q;
      resp_data_d  = resp_data_q;
      count_d      = count_q;

      case (state_q)
         IDLE: begin
            if (req0_ready_o | req1_ready_o) begin
               src_d        = req1_ready_o;
               last_grant_d = req1_ready_o;
               op1_d        = req1_ready_o ? req1_op1_i : req0_op1_i;
               op2_d        = req1_ready_o ? req1_op2_i : req0_op2_i;
               op_d         = req1_ready_o ? req1_op_i  : req0_op_i;
               tag_d        = req1_ready_o ? req1_tag_i : req0_tag_i;
               count_d      = 8'd0;
               start_d      = 1'b1;
               state_d      = EXEC;
            end
         end
         EXEC: begin
            count_d = count_q + 8'd1;
            if (flush_i) begin
               state_d = IDLE;
            end else if (exec_done) begin
               resp_data_d  = mdu_result_i;
               resp_valid_d = 1'b1;
               state_d      = RESP;
            end else if (timeout_o) begin
               state_d = IDLE;
            end
         end
         RESP: begin
            if (flush_i | resp_ready_i) begin
               resp_valid_d = 1'b0;
               state_d      = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         last_grant_q <= 1'b1;
         op1_q        <= '0;
         op2_q        <= '0;
         op_q         <= '0;
         tag_q        <= '0;
         src_q        <= 1'b0;
         start_q      <= 1'b0;
         resp_valid_q <= 1'b0;
         resp_data_q  <= '0;
         count_q      <= '0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         op1_q        <= op1_d;
         op2_q        <= op2_d;
         op_q         <= op_d;
         tag_q        <= tag_d;
         src_q        <= src_d;
         start_q      <= start_d;
         resp_valid_q <= resp_valid_d;
         resp_data_q  <= resp_data_d;
         count_q      <= count_d;
      end
   end

   assign mdu_start_o  = start_q;
   assign mdu_op1_o    = op1_q;
   assign mdu_op2_o    = op2_q;
   assign mdu_op_o     = op_q;
   assign resp_valid_o = resp_valid_q;
   assign resp_data_o  = resp_data_q;
   assign resp_tag_o   = tag_q;
   assign resp_src_o   = src_q;
   assign busy_o       = (state_q != IDLE);
endmodule

// File: tb/tb_muldiv_arbiter.sv
// Bench for muldiv_arbiter: directed ops against a small MDU model, responses
// checked by a monitor against an expected queue of {src, tag, data}.
module tb_muldiv_arbiter;
   localparam int TAG_W = 4;
   localparam int EW    = 1 + TAG_W + 32;

   logic             clk = 1'b0;
   logic             rst;
   logic             flush_i;
   logic             req0_valid_i, req1_valid_i;
   logic             req0_ready_o, req1_ready_o;
   logic [31:0]      req0_op1_i, req0_op2_i, req1_op1_i, req1_op2_i;
   logic [7:0]       req0_op_i, req1_op_i;
   logic [TAG_W-1:0] req0_tag_i, req1_tag_i;
   logic             mdu_start_o;
   logic [31:0]      mdu_op1_o, mdu_op2_o;
   logic [7:0]       mdu_op_o;
   logic             mdu_done_i;
   logic [31:0]      mdu_result_i;
   logic             resp_valid_o, resp_ready_i;
   logic [31:0]      resp_data_o;
   logic [TAG_W-1:0] resp_tag_o;
   logic             resp_src_o, busy_o, timeout_o;

   int checks = 0;
   int errors = 0;
   logic [EW-1:0] exp_q[$];

   // MDU model controls: latency 0 means the unit never finishes.
   int          mdu_lat   = 4;
   bit          use_fixed = 1'b0;
   logic [31:0] fixed_res = '0;
   bit          pending   = 1'b0;
   int          rem       = 0;
   logic [31:0] res_hold  = '0;

   muldiv_arbiter #(.TAG_W(TAG_W), .TIMEOUT(8)) dut (
      .clk(clk), .rst(rst), .flush_i(flush_i),
      .req0_valid_i(req0_valid_i), .req0_ready_o(req0_ready_o),
      .req0_op1_i(req0_op1_i), .req0_op2_i(req0_op2_i), .req0_op_i(req0_op_i), .req0_tag_i(req0_tag_i),
      .req1_valid_i(req1_valid_i), .req1_ready_o(req1_ready_o),
      .req1_op1_i(req1_op1_i), .req1_op2_i(req1_op2_i), .req1_op_i(req1_op_i), .req1_tag_i(req1_tag_i),
      .mdu_start_o(mdu_start_o), .mdu_op1_o(mdu_op1_o), .mdu_op2_o(mdu_op2_o), .mdu_op_o(mdu_op_o),
      .mdu_done_i(mdu_done_i), .mdu_result_i(mdu_result_i),
      .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i), .resp_data_o(resp_data_o),
      .resp_tag_o(resp_tag_o), .resp_src_o(resp_src_o),
      .busy_o(busy_o), .timeout_o(timeout_o)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1);
   end

   // ---------------- MDU model ----------------
   initial begin
      mdu_done_i   = 1'b0;
      mdu_result_i = '0;
      forever begin
         @(posedge clk);
         #1;
         mdu_done_i = 1'b0;
         if (rst) begin
            pending = 1'b0;
         end else begin
            if (pending) begin
               rem = rem - 1;
               if (rem == 0) begin
                  mdu_done_i   = 1'b1;
                  mdu_result_i = res_hold;
                  pending      = 1'b0;
               end
            end
            if (mdu_start_o && mdu_lat > 0) begin
               pending  = 1'b1;
               rem      = mdu_lat;
               res_hold = use_fixed ? fixed_res : mdu_op1_o * mdu_op2_o;
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input int idx, input logic [31:0] a, input logic [31:0] b,
                        input logic [7:0] op, input logic [TAG_W-1:0] tag,
                        input bit exp_resp, input logic [31:0] exp_data);
      bit got = 1'b0;
      if (idx == 0) begin
         req0_valid_i = 1'b1; req0_op1_i = a; req0_op2_i = b; req0_op_i = op; req0_tag_i = tag;
      end else begin
         req1_valid_i = 1'b1; req1_op1_i = a; req1_op2_i = b; req1_op_i = op; req1_tag_i = tag;
      end
      for (int i = 0; i < 40 && !got; i++) begin
         @(negedge clk);
         if ((idx == 0) ? req0_ready_o : req1_ready_o) got = 1'b1;
      end
      check($sformatf("accept_req%0d", idx), 64'(got), 64'd1);
      if (got && exp_resp) exp_q.push_back({1'(idx), tag, exp_data});
      @(posedge clk);
      #1;
      if (idx == 0) req0_valid_i = 1'b0;
      else req1_valid_i = 1'b0;
   endtask

   task automatic wait_idle();
      bit idle = 1'b0;
      for (int i = 0; i < 100 && !idle; i++) begin
         @(negedge clk);
         if (!busy_o && !resp_valid_o) idle = 1'b1;
      end
      check("wait_idle", 64'(idle), 64'd1);
      check("queue_empty_at_idle", 64'(exp_q.size()), 64'd0);
      tick();
   endtask

   // ---------------- scoreboard monitor ----------------
   always @(negedge clk) begin
      if (!rst && resp_valid_o && resp_ready_i && !flush_i) begin
         if (exp_q.size() == 0) begin
            check("unexpected_resp", 64'({resp_src_o, resp_tag_o, resp_data_o}), 64'd0);
         end else begin
            check("resp_src_tag_data", 64'({resp_src_o, resp_tag_o, resp_data_o}),
                  64'(exp_q.pop_front()));
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      int busy_cnt;
      int gcount;
      bit seen;
      rst = 1'b1; flush_i = 1'b0; resp_ready_i = 1'b1;
      req0_valid_i = 1'b0; req0_op1_i = '0; req0_op2_i = '0; req0_op_i = '0; req0_tag_i = '0;
      req1_valid_i = 1'b0; req1_op1_i = '0; req1_op2_i = '0; req1_op_i = '0; req1_tag_i = '0;
      repeat (3) tick();
      @(negedge clk);
      check("reset_ctl", 64'({busy_o, mdu_start_o, resp_valid_o, timeout_o, req0_ready_o, req1_ready_o}), 64'd0);
      check("reset_data", 64'({mdu_op1_o, resp_data_o}), 64'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      tick();

      // Single op: 7*6 -> 42, MDU done 4 cycles after start.
      mdu_lat = 4;
      issue(0, 32'd7, 32'd6, 8'h01, 4'd3, 1'b1, 32'd42);
      @(negedge clk);
      check("t1_start_pulse", 64'(mdu_start_o), 64'd1);
      check("t1_mdu_ops", 64'({mdu_op1_o[15:0], mdu_op2_o[15:0], mdu_op_o}), 64'h0007_0006_01);
      check("t1_busy", 64'(busy_o), 64'd1);
      @(negedge clk);
      check("t1_start_one_cycle", 64'(mdu_start_o), 64'd0);
      busy_cnt = 2;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (!busy_o) break;
         busy_cnt++;
      end
      check("t1_busy_cycles", 64'(busy_cnt), 64'd6);
      check("t1_queue_drained", 64'(exp_q.size()), 64'd0);
      tick();

      // Contention from a fresh reset: grants alternate 0,1,0,1.
      rst = 1'b1;
      tick();
      rst = 1'b0;
      mdu_lat = 1;
      req0_op1_i = 32'd3; req0_op2_i = 32'd5;  req0_op_i = 8'h01; req0_tag_i = 4'd5;
      req1_op1_i = 32'd4; req1_op2_i = 32'd11; req1_op_i = 8'h02; req1_tag_i = 4'd9;
      req0_valid_i = 1'b1; req1_valid_i = 1'b1;
      gcount = 0;
      for (int i = 0; i < 60 && gcount < 4; i++) begin
         @(negedge clk);
         if (req0_ready_o || req1_ready_o) begin
            check($sformatf("t2_grant%0d", gcount), 64'({req0_ready_o, req1_ready_o}),
                  (gcount % 2 == 0) ? 64'b10 : 64'b01);
            if (gcount % 2 == 0) exp_q.push_back({1'b0, 4'd5, 32'd15});
            else exp_q.push_back({1'b1, 4'd9, 32'd44});
            gcount++;
         end
      end
      check("t2_grant_count", 64'(gcount), 64'd4);
      @(posedge clk);
      #1;
      req0_valid_i = 1'b0; req1_valid_i = 1'b0;
      wait_idle();

      // Backpressure in RESP with req0 waiting.
      resp_ready_i = 1'b0;
      mdu_lat = 2;
      issue(1, 32'd100, 32'd3, 8'h04, 4'd12, 1'b1, 32'd300);
      req0_op1_i = 32'd2; req0_op2_i = 32'd2; req0_op_i = 8'h01; req0_tag_i = 4'd1;
      req0_valid_i = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         if (resp_valid_o) seen = 1'b1;
      end
      check("t3_resp_seen", 64'(seen), 64'd1);
      for (int j = 0; j < 5; j++) begin
         check($sformatf("t3_hold%0d", j),
               64'({resp_valid_o, resp_data_o, resp_tag_o, resp_src_o, req0_ready_o, req1_ready_o}),
               64'({1'b1, 32'd300, 4'd12, 1'b1, 1'b0, 1'b0}));
         if (j < 4) @(negedge clk);
      end
      @(posedge clk);
      #1;
      resp_ready_i = 1'b1;
      @(negedge clk);
      check("t3_ready_in_handshake", 64'(req0_ready_o), 64'd0);
      @(negedge clk);
      check("t3_ready_after_handshake", 64'(req0_ready_o), 64'd1);
      if (req0_ready_o) exp_q.push_back({1'b0, 4'd1, 32'd4});
      @(posedge clk);
      #1;
      req0_valid_i = 1'b0;
      wait_idle();

      // Flush two cycles after start; stale 0xDEAD done must be ignored.
      use_fixed = 1'b1; fixed_res = 32'hDEAD; mdu_lat = 5;
      issue(0, 32'd1, 32'd1, 8'h10, 4'd2, 1'b0, 32'd0);
      tick();
      tick();
      flush_i = 1'b1;
      tick();
      flush_i = 1'b0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         check($sformatf("t4_quiet%0d", k), 64'({busy_o, resp_valid_o, mdu_start_o}), 64'd0);
      end
      tick();
      use_fixed = 1'b0; mdu_lat = 2;
      issue(1, 32'd9, 32'd9, 8'h01, 4'd7, 1'b1, 32'd81);
      wait_idle();

      // Flush together with done.
      mdu_lat = 3;
      issue(0, 32'd5, 32'd5, 8'h01, 4'd4, 1'b0, 32'd0);
      tick();
      tick();
      tick();
      check("t5_done_now", 64'(mdu_done_i), 64'd1);
      flush_i = 1'b1;
      tick();
      flush_i = 1'b0;
      @(negedge clk);
      check("t5_flush_done", 64'({busy_o, resp_valid_o}), 64'd0);
      tick();

      // Flush in RESP while the consumer is ready.
      mdu_lat = 2;
      issue(1, 32'd6, 32'd6, 8'h01, 4'd8, 1'b0, 32'd0);
      tick();
      tick();
      tick();
      check("t5_in_resp", 64'(resp_valid_o), 64'd1);
      flush_i = 1'b1;
      tick();
      flush_i = 1'b0;
      @(negedge clk);
      check("t5_flush_resp", 64'({busy_o, resp_valid_o}), 64'd0);
      tick();

      // Watchdog with TIMEOUT=8: MDU never completes.
      mdu_lat = 0;
      issue(0, 32'd2, 32'd3, 8'h01, 4'd6, 1'b0, 32'd0);
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         check($sformatf("t6_timeout_c%0d", k), 64'(timeout_o), (k == 8) ? 64'd1 : 64'd0);
      end
      @(negedge clk);
      check("t6_after_timeout", 64'({busy_o, timeout_o, resp_valid_o}), 64'd0);
      tick();

      // Asynchronous reset in the middle of EXEC.
      issue(1, 32'h55, 32'h66, 8'h80, 4'hA, 1'b0, 32'd0);
      tick();
      check("t6_mid_exec", 64'({busy_o, mdu_op1_o}), 64'({1'b1, 32'h55}));
      #2;
      rst = 1'b1;
      #1;
      check("t6_async_ctl", 64'({busy_o, mdu_start_o, resp_valid_o, timeout_o, resp_src_o, resp_tag_o}), 64'd0);
      check("t6_async_data", 64'({mdu_op1_o, mdu_op2_o[23:0], mdu_op_o}), 64'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (3) tick();

      check("final_queue_empty", 64'(exp_q.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
